// File: rtl/axis_packer.sv
// AXI4-Stream byte packer: compacts sparse tkeep lanes into dense low-aligned beats and folds null-tlast beats.
// Optional statistics outputs are enabled by defining AXIS_PACKER_STATS_EN.
module axis_packer #(
  parameter int BYTES = 4,
  localparam int WIDTH = 8 * BYTES,
  localparam int CBITS = $clog2(BYTES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [BYTES-1:0] s_tkeep,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [BYTES-1:0] m_tkeep,
  output logic [WIDTH-1:0] m_tdata
`ifdef AXIS_PACKER_STATS_EN
  ,
  output logic [15:0]      pkt_count_o,
  output logic [15:0]      null_count_o
`endif
);

  logic [WIDTH-1:0]   r_data;
  logic [CBITS-1:0]   r_count;
  logic               rflush;
  logic               h_valid;
  logic               h_known;
  logic               h_last;
  logic [BYTES-1:0]   h_keep;
  logic [WIDTH-1:0]   h_data;

  logic [2*WIDTH-1:0] merged;
  int                 total;
  logic               acc;
  logic               keep_nz;
  logic               o_free;
  logic               full;
  logic               fold;
  logic               h_move;

  function automatic logic [BYTES-1:0] keep_mask(input int n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i < n);
    return m;
  endfunction

  // Append kept lanes, in ascending order, behind the residual bytes.
  always_comb begin
    merged = {{WIDTH{1'b0}}, r_data};
    total  = int'(r_count);
    for (int i = 0; i < BYTES; i++) begin
      if (s_tkeep[i]) begin
        merged[8*total +: 8] = s_tdata[8*i +: 8];
        total = total + 1;
      end
    end
  end

  // Any accepted beat that yields a word or closes the packet also resolves H, so O must be free to take it.
  assign s_tready = !reset && !rflush && (!h_valid || o_free);
  assign acc      = s_tvalid && s_tready;
  assign keep_nz  = |s_tkeep;
  assign o_free   = !m_tvalid || m_tready;
  assign full     = total >= BYTES;
  assign fold     = acc && s_tlast && (total == 0) && h_valid && !h_known;
  assign h_move   = h_valid && o_free && (h_known || (acc && (keep_nz || s_tlast)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_count  <= '0;
      rflush   <= 1'b0;
      h_valid  <= 1'b0;
      h_known  <= 1'b0;
      h_last   <= 1'b0;
      h_keep   <= '0;
      h_data   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tkeep  <= '0;
      m_tdata  <= '0;
    end else begin
      if (h_move) begin
        m_tvalid <= 1'b1;
        m_tlast  <= h_last || fold;
        m_tkeep  <= h_keep;
        m_tdata  <= h_data;
        h_valid  <= 1'b0;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (rflush) begin
        // The pending tail of an overflowing last beat follows the word ahead of it.
        if (h_move) begin
          h_valid <= 1'b1;
          h_known <= 1'b1;
          h_last  <= 1'b1;
          h_keep  <= keep_mask(int'(r_count));
          h_data  <= r_data;
          r_count <= '0;
          rflush  <= 1'b0;
        end
      end else if (acc) begin
        if (full) begin
          h_valid <= 1'b1;
          h_known <= s_tlast;
          h_last  <= s_tlast && (total == BYTES);
          h_keep  <= '1;
          h_data  <= merged[WIDTH-1:0];
          r_data  <= merged[2*WIDTH-1:WIDTH];
          r_count <= CBITS'(total - BYTES);
          rflush  <= s_tlast && (total > BYTES);
        end else if (s_tlast && (total > 0)) begin
          h_valid <= 1'b1;
          h_known <= 1'b1;
          h_last  <= 1'b1;
          h_keep  <= keep_mask(total);
          h_data  <= merged[WIDTH-1:0];
          r_count <= '0;
        end else begin
          r_data  <= merged[WIDTH-1:0];
          r_count <= s_tlast ? '0 : CBITS'(total);
        end
      end
    end
  end

`ifdef AXIS_PACKER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count_o  <= '0;
      null_count_o <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast) pkt_count_o <= pkt_count_o + 16'd1;
      if (acc && !keep_nz) null_count_o <= null_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packer.sv
// Directed bench for axis_packer (BYTES=4): hand-computed output beats plus a random-packet byte stream section.
module tb_axis_packer;
  localparam int BYTES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tkeep = '0;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [3:0]  m_tkeep;
  logic [31:0] m_tdata;
`ifdef AXIS_PACKER_STATS_EN
  logic [15:0] pkt_count_o;
  logic [15:0] null_count_o;
`endif

  axis_packer #(.BYTES(BYTES)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep), .m_tdata(m_tdata)
`ifdef AXIS_PACKER_STATS_EN
    , .pkt_count_o(pkt_count_o), .null_count_o(null_count_o)
`endif
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] obs_data[$];
  logic [3:0]  obs_keep[$];
  logic        obs_last[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];
  logic        exp_last[$];

  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [37:0] held = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Record every handshake and require O to stay frozen across a stalled cycle.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("hold", 64'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 64'(held));
      if (m_tvalid && m_tready) begin
        obs_data.push_back(m_tdata);
        obs_keep.push_back(m_tkeep);
        obs_last.push_back(m_tlast);
      end
      prev_stall = m_tvalid && !m_tready;
      held = {m_tvalid, m_tlast, m_tkeep, m_tdata};
    end
  end

  always @(posedge clock) begin
    if (rand_ready) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input logic [3:0] keep, input logic [31:0] data, input logic last);
    logic accepted;
    accepted = 1'b0;
    s_tvalid = 1'b1;
    s_tkeep  = keep;
    s_tdata  = data;
    s_tlast  = last;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clock);
      if (s_tready) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(0), 64'(1));
    @(posedge clock);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic expectBeat(input logic [31:0] data, input logic [3:0] keep, input logic last);
    exp_data.push_back(data);
    exp_keep.push_back(keep);
    exp_last.push_back(last);
  endtask

  task automatic checkStream(input string tag);
    logic [31:0] mask;
    repeat (20) @(negedge clock);
    checkOutput({tag, "_beats"}, 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{exp_keep[i][b]}};
      checkOutput({tag, "_keep"}, 64'(obs_keep[i]), 64'(exp_keep[i]));
      checkOutput({tag, "_last"}, 64'(obs_last[i]), 64'(exp_last[i]));
      checkOutput({tag, "_data"}, 64'(obs_data[i] & mask), 64'(exp_data[i] & mask));
    end
    obs_data.delete(); obs_keep.delete(); obs_last.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] bytes[$];
    logic [31:0] d;
    logic [3:0] k;
    int nb, n;

    #12;
    checkOutput("rst_tready", 64'(s_tready), 64'(0));
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("rst_tkeep", 64'(m_tkeep), 64'(0));
    checkOutput("rst_tlast", 64'(m_tlast), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 64'(s_tready), 64'(1));

    applyStimulus(4'hF, 32'h03020100, 1'b0);
    applyStimulus(4'hF, 32'h07060504, 1'b1);
    expectBeat(32'h03020100, 4'hF, 1'b0);
    expectBeat(32'h07060504, 4'hF, 1'b1);
    checkStream("dense");

    applyStimulus(4'h5, 32'hEE22EE11, 1'b0);
    applyStimulus(4'hA, 32'h44EE33EE, 1'b1);
    expectBeat(32'h44332211, 4'hF, 1'b1);
    checkStream("sparse");

    applyStimulus(4'hF, 32'h0D0C0B0A, 1'b0);
    applyStimulus(4'h0, 32'hDEADBEEF, 1'b1);
    expectBeat(32'h0D0C0B0A, 4'hF, 1'b1);
    checkStream("null_fold");

    applyStimulus(4'h7, 32'hEE030201, 1'b0);
    applyStimulus(4'hF, 32'h07060504, 1'b1);
    @(negedge clock);
    checkOutput("ovf_stall", 64'(s_tready), 64'(0));
    expectBeat(32'h04030201, 4'hF, 1'b0);
    expectBeat(32'h00070605, 4'h7, 1'b1);
    checkStream("overflow");

    applyStimulus(4'h0, 32'h11111111, 1'b0);
    applyStimulus(4'h0, 32'h22222222, 1'b1);
    checkStream("null_pkt");

    // Two words fill O and H, so the third beat must wait for the consumer.
    m_tready = 1'b0;
    applyStimulus(4'hF, 32'h13121110, 1'b0);
    applyStimulus(4'hF, 32'h17161514, 1'b0);
    s_tvalid = 1'b1; s_tkeep = 4'hF; s_tdata = 32'h1B1A1918; s_tlast = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("bp_ready", 64'(s_tready), 64'(0));
      checkOutput("bp_data", 64'(m_tdata), 64'h13121110);
    end
    @(posedge clock);
    #1;
    m_tready = 1'b1;
    applyStimulus(4'hF, 32'h1B1A1918, 1'b0);
    applyStimulus(4'hF, 32'h1F1E1D1C, 1'b1);
    expectBeat(32'h13121110, 4'hF, 1'b0);
    expectBeat(32'h17161514, 4'hF, 1'b0);
    expectBeat(32'h1B1A1918, 4'hF, 1'b0);
    expectBeat(32'h1F1E1D1C, 4'hF, 1'b1);
    checkStream("backpressure");

    m_tready = 1'b0;
    applyStimulus(4'hF, 32'h23222120, 1'b0);
    applyStimulus(4'hF, 32'h27262524, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("midrst_tready", 64'(s_tready), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_tready = 1'b1;

    applyStimulus(4'h0, 32'h55555555, 1'b0);
    applyStimulus(4'hF, 32'hA3A2A1A0, 1'b1);
    applyStimulus(4'h3, 32'hEEEEB1B0, 1'b0);
    applyStimulus(4'h0, 32'h66666666, 1'b1);
    applyStimulus(4'h8, 32'hC0EEEEEE, 1'b1);
    expectBeat(32'hA3A2A1A0, 4'hF, 1'b1);
    expectBeat(32'h0000B1B0, 4'h3, 1'b1);
    expectBeat(32'h000000C0, 4'h1, 1'b1);
    checkStream("post_reset");
`ifdef AXIS_PACKER_STATS_EN
    checkOutput("pkt_count", 64'(pkt_count_o), 64'(3));
    checkOutput("null_count", 64'(null_count_o), 64'(2));
`endif

    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        k = 4'($urandom_range(0, 15));
        d = $urandom;
        for (int l = 0; l < 4; l++) if (k[l]) bytes.push_back(d[8*l +: 8]);
        applyStimulus(k, d, b == nb - 1);
      end
      while (bytes.size() > 0) begin
        n = (bytes.size() < 4) ? bytes.size() : 4;
        d = '0;
        for (int l = 0; l < n; l++) d[8*l +: 8] = bytes.pop_front();
        expectBeat(d, 4'((1 << n) - 1), bytes.size() == 0);
      end
    end
    rand_ready = 1'b0;
    @(posedge clock);
    #2;
    m_tready = 1'b1;
    checkStream("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
